msk_state_unloader: RTL and testbench

- Reader-side counterpart of the masked scan register: captures a full masked state in one cycle, then unloads it word by word over a valid/ready stream.
- Sits at the output of the masked core. Hands shared ciphertext words to the unmasking/output stage without ever recombining shares.
- The internal buffer is a masked scan chain: load on capture, shift by one word per accepted output beat.

---
 rtl/msk_state_unloader.sv | 95 +++++++++
 tb/tb_msk_state_unloader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/msk_state_unloader.sv
// Masked state unloader: captures a full shared state in one cycle, then streams it out
// one masked word per accepted beat. Optional macro: MSK_UNLOAD_CLEAR_EN (zero refill/clear).
module msk_state_unloader #(
    parameter int d      = 2,
    parameter int WORD   = 32,
    parameter int NWORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NWORDS*WORD*d-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD*d-1:0]          out_data,
    output logic                       out_last
);

    localparam int SW = WORD * d;
    localparam int BW = NWORDS * SW;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_buf;
    logic [SW-1:0]   w_refill;
    logic            w_capture;
    logic            w_beat;

    assign w_capture = in_valid & in_ready;
    assign w_beat    = out_valid & out_ready;
    assign out_data  = r_buf[SW-1:0];

`ifdef MSK_UNLOAD_CLEAR_EN
    assign w_refill = '0;
`else
    assign w_refill = r_buf[SW-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_state   <= BUSY;
                        r_cnt     <= '0;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (r_cnt == LAST) begin
                            r_state   <= IDLE;
                            r_cnt     <= '0;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt + 1'b1;
                            out_last <= (r_cnt == LAST - 1'b1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan chain: each bit is a plain mux+flop, so the d shares of a bit never meet a shared gate.
    // NOTE: the wide buffer carries no reset by default; control state alone defines validity.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef MSK_UNLOAD_CLEAR_EN
            r_buf <= '0;
`endif
        end else if (w_capture) begin
            r_buf <= in_data;
        end else if (w_beat) begin
            r_buf <= {w_refill, r_buf[BW-1:SW]};
        end
    end

endmodule

// File: tb/tb_msk_state_unloader.sv
// Scoreboard bench for msk_state_unloader: expected words queued at capture, popped on handshake.
module tb_msk_state_unloader;

    localparam int D      = 2;
    localparam int WORD   = 32;
    localparam int NWORDS = 4;
    localparam int SW     = WORD * D;
    localparam int BW     = NWORDS * SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_data;
    logic          out_last;

    int errors = 0;
    int checks = 0;

    logic [SW:0]     exp_q[$];
    logic [WORD-1:0] plain_q[$];
    logic [BW-1:0]   last_state;

    always #5 clk = ~clk;

    msk_state_unloader #(.d(D), .WORD(WORD), .NWORDS(NWORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    // Word i = {share1, share0}; plaintext of a word is share1 ^ share0.
    function automatic logic [BW-1:0] make_state(input logic [WORD-1:0] hi, input logic [WORD-1:0] lo);
        logic [BW-1:0] s;
        for (int i = 0; i < NWORDS; i++) s[i*SW +: SW] = {hi + WORD'(i), lo + WORD'(i)};
        return s;
    endfunction

    task automatic push_expected(input logic [BW-1:0] s, input logic [WORD-1:0] hi, input logic [WORD-1:0] lo);
        for (int i = 0; i < NWORDS; i++) begin
            exp_q.push_back({(i == NWORDS - 1), s[i*SW +: SW]});
            plain_q.push_back((hi + WORD'(i)) ^ (lo + WORD'(i)));
        end
        last_state = s;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_capture(input logic [WORD-1:0] hi, input logic [WORD-1:0] lo);
        int waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL capture_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = make_state(hi, lo);
        push_expected(in_data, hi, lo);
    endtask

    // Cycle k is the k-th falling edge after the capture edge; stall[k] drops out_ready that cycle.
    task automatic unload(input logic [63:0] stall, input bit hold_next, input logic [BW-1:0] nxt,
                          input int abort_after, output int cycles);
        int k = 0;
        int beats = 0;
        logic [SW:0] e;
        logic [WORD-1:0] p;
        while (exp_q.size() > 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (hold_next) begin
                in_valid = 1'b1;
                in_data  = nxt;
            end else begin
                in_valid = 1'b0;
            end
            e = exp_q[0];
            p = plain_q[0];
            checks++;
            if ({out_valid, in_ready, out_last, out_data} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL word%0d_cycle%0d: valid=%b in_ready=%b last=%b data=%h required valid=1 in_ready=0 last=%b data=%h",
                         NWORDS - exp_q.size(), k, out_valid, in_ready, out_last, out_data, e[SW], e[SW-1:0]);
            end
            checks++;
            if ((out_data[SW-1 -: WORD] ^ out_data[WORD-1:0]) !== p) begin
                errors++;
                $display("FAIL plain_word%0d: got %h required %h", NWORDS - exp_q.size(),
                         out_data[SW-1 -: WORD] ^ out_data[WORD-1:0], p);
            end
            out_ready = ~stall[k];
            if (out_ready) begin
                void'(exp_q.pop_front());
                void'(plain_q.pop_front());
                beats++;
                if (beats == abort_after) break;
            end
        end
        cycles = k;
        if (abort_after == 0) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL unload_timeout: %0d words left required 0", exp_q.size());
                exp_q.delete();
                plain_q.delete();
            end
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_last} !== 3'b100) begin
                errors++;
                $display("FAIL after_last: in_ready=%b valid=%b last=%b required 1 0 0", in_ready, out_valid, out_last);
            end
        end
    endtask

    task automatic check_buffer(input string name, input logic [BW-1:0] kept);
        logic [BW-1:0] want;
`ifdef MSK_UNLOAD_CLEAR_EN
        want = '0;
`else
        want = kept;
`endif
        checks++;
        if (dut.r_buf !== want) begin
            errors++;
            $display("FAIL %s: buffer=%h required %h", name, dut.r_buf, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid, out_last} !== 3'b100) begin
                errors++;
                $display("FAIL reset_idle%0d: in_ready=%b valid=%b last=%b required 1 0 0", i, in_ready, out_valid, out_last);
            end
        end
    endtask

    task automatic test_full_unload();
        int c;
        start_capture(32'hA0A0A0A0, 32'h0F0F0F00);
        unload(64'h0, 1'b0, '0, 0, c);
        checks++;
        if (c !== NWORDS) begin
            errors++;
            $display("FAIL full_cycles: got %0d required %0d", c, NWORDS);
        end
        check_buffer("full_buffer", last_state);
    endtask

    task automatic test_backpressure();
        int c;
        start_capture(32'hA0A0A0A0, 32'h0F0F0F00);
        unload(64'h9C, 1'b0, '0, 0, c);
        checks++;
        if (c !== NWORDS + 4) begin
            errors++;
            $display("FAIL stall_cycles: got %0d required %0d", c, NWORDS + 4);
        end
        check_buffer("stall_buffer", last_state);
    endtask

    task automatic test_back_to_back();
        int c;
        logic [BW-1:0] s2;
        s2 = make_state(32'h11112222, 32'h5A5A0000);
        start_capture(32'hA0A0A0A0, 32'h0F0F0F00);
        unload(64'h0, 1'b1, s2, 0, c);
        checks++;
        if (c !== NWORDS) begin
            errors++;
            $display("FAIL b2b_first_cycles: got %0d required %0d", c, NWORDS);
        end
        push_expected(s2, 32'h11112222, 32'h5A5A0000);
        unload(64'h0, 1'b0, '0, 0, c);
        check_buffer("b2b_buffer", s2);
    endtask

    task automatic test_reset_mid();
        int c;
        logic [BW-1:0] s;
        start_capture(32'hA0A0A0A0, 32'h0F0F0F00);
        s = in_data;
        unload(64'h0, 1'b0, '0, 2, c);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if ({in_ready, out_valid, out_last} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b valid=%b last=%b required 1 0 0", in_ready, out_valid, out_last);
        end
        check_buffer("reset_mid_buffer", {s[2*SW-1:0], s[BW-1:2*SW]});
        exp_q.delete();
        plain_q.delete();
        start_capture(32'hC3C3C3C3, 32'h12345678);
        unload(64'h0, 1'b0, '0, 0, c);
        check_buffer("restart_buffer", last_state);
    endtask

    initial begin
        test_reset();
        test_full_unload();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
